// File: rtl/psi_t_rx_pkg.sv
// psi_t_rx_pkg: shared types and constants for the psi_t receive path.
// Holds the FSM state encoding, the data width and a reference constant.
package psi_t_rx_pkg;
  localparam int DW = 64;
  localparam logic [DW-1:0] FP_NEG_SIXTH = 64'hBFC5555555555555;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
endpackage

// File: rtl/psi_t_rx_fifo.sv
// psi_t_rx_fifo: synchronous FIFO with count, full/empty and registered almost_full.
// Ports: clk, rst_n (async active-low), wr/din (write), rd/dout (pop, head word),
//        count (entries held), full, empty, almost_full (free <= AFULL_MARGIN).
module psi_t_rx_fifo
  import psi_t_rx_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr,
  input  logic [DW-1:0]              din,
  input  logic                       rd,
  output logic [DW-1:0]              dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wp, rp, cnt_nxt;
  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign cnt_nxt = count + (AW+1)'(wr) - (AW+1)'(rd);
  // Head is read straight from storage flops, so it appears the cycle after the write.
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      almost_full <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + (AW+1)'(1);
      end
      if (rd) rp <= rp + (AW+1)'(1);
      almost_full <= (DEPTH - int'(cnt_nxt)) <= AFULL_MARGIN;
    end
endmodule

// File: rtl/psi_t_rx.sv
// psi_t_rx: buffers psi_t result words and streams them out in frames.
// Ports: clk, rst_n (async active-low); psi_t/psi_t_vld producer input (no backpressure);
//        flush closes the current frame early; clr_ovf clears the sticky overflow;
//        m_tdata/m_tvalid/m_tready/m_tlast downstream stream; almost_full to the issuer;
//        overflow is set when an input beat is dropped.
// Optional: define PSI_T_RX_STATS_EN to add saturating beat_cnt/drop_cnt outputs.
module psi_t_rx
  import psi_t_rx_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FRAME_LEN    = 8,
  parameter int AFULL_MARGIN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] psi_t,
  input  logic          psi_t_vld,
  input  logic          flush,
  input  logic          clr_ovf,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          almost_full,
  output logic          overflow
`ifdef PSI_T_RX_STATS_EN
  ,
  output logic [31:0]   beat_cnt,
  output logic [31:0]   drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] LAST = FW'(FRAME_LEN - 1);
  state_t state, state_nxt;
  logic [AW:0] count, rem, cnt_after, drain_left;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic full, empty, pop, accept, drop, last_pop, drain_end, flush_go;
  psi_t_rx_fifo #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr(accept),
    .din(psi_t),
    .rd(pop),
    .dout(m_tdata),
    .count(count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full)
  );
  assign m_tvalid = !empty;
  assign pop = m_tvalid && m_tready;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign accept = psi_t_vld && (!full || pop);
  assign drop = psi_t_vld && full && !pop;
  assign last_pop = pop && m_tlast;
  assign fcnt_nxt = last_pop ? '0 : pop ? fcnt + FW'(1) : fcnt;
  assign rem = count - (AW+1)'(pop);
  assign cnt_after = count + (AW+1)'(accept) - (AW+1)'(pop);
  // drain_left == 0 means every pre-flush entry is gone: the next beat closes the frame.
  assign drain_end = (state == DRAIN) && (drain_left <= (AW+1)'(1));
  // A flush only matters if something of the current frame is still pending.
  assign flush_go = (state == ACTIVE) && flush && (rem != '0 || fcnt_nxt != '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? ACTIVE : IDLE;
      ACTIVE:  state_nxt = flush_go ? DRAIN : (last_pop && cnt_after == '0) ? IDLE : ACTIVE;
      DRAIN:   state_nxt = (last_pop && drain_end) ? ((cnt_after != '0) ? ACTIVE : IDLE) : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb m_tlast = m_tvalid && (fcnt == LAST || drain_end);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fcnt <= '0;
      drain_left <= '0;
      overflow <= 1'b0;
    end else begin
      fcnt <= fcnt_nxt;
      if (flush_go) drain_left <= rem;
      else if (state == DRAIN && pop && drain_left != '0) drain_left <= drain_left - (AW+1)'(1);
      overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
    end
`ifdef PSI_T_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept && ~&beat_cnt) beat_cnt <= beat_cnt + 32'd1;
      if (drop && ~&drop_cnt) drop_cnt <= drop_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_psi_t_rx.sv
// tb_psi_t_rx: directed self-checking bench for psi_t_rx (DEPTH=16, FRAME_LEN=8, AFULL_MARGIN=4).
module tb_psi_t_rx;
  import psi_t_rx_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] psi_t = '0;
  logic psi_t_vld = 1'b0, flush = 1'b0, clr_ovf = 1'b0, m_tready = 1'b0;
  logic [63:0] m_tdata;
  logic m_tvalid, m_tlast, almost_full, overflow;
`ifdef PSI_T_RX_STATS_EN
  logic [31:0] beat_cnt, drop_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  psi_t_rx dut (
    .clk(clk),
    .rst_n(rst_n),
    .psi_t(psi_t),
    .psi_t_vld(psi_t_vld),
    .flush(flush),
    .clr_ovf(clr_ovf),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast(m_tlast),
    .almost_full(almost_full),
    .overflow(overflow)
`ifdef PSI_T_RX_STATS_EN
    ,
    .beat_cnt(beat_cnt),
    .drop_cnt(drop_cnt)
`endif
  );
  typedef struct {
    logic vld;
    logic [63:0] d;
    logic rdy;
    logic fl;
    logic ev;
    logic [63:0] ed;
    logic el;
  } vec_t;
  vec_t tbl[11];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic vld, input logic [63:0] d, input logic rdy, input logic fl, input logic clr);
    @(negedge clk);
    psi_t_vld = vld;
    psi_t = d;
    m_tready = rdy;
    flush = fl;
    clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    psi_t_vld = 1'b0;
    flush = 1'b0;
    clr_ovf = 1'b0;
    m_tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [63:0] dk;
    logic [63:0] fl_data [5];
    logic fl_last [5];
    tbl[0] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0};
    for (int k = 1; k <= 8; k++) begin
      dk = (k == 1) ? 64'h3FF0000000000000 : (k == 2) ? FP_NEG_SIXTH : 64'h4000000000000000 + 64'(k);
      tbl[k] = '{1'b1, dk, 1'b1, 1'b0, 1'b1, dk, k == 8};
    end
    tbl[9] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[10] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    // single write and full 8-beat frame
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].vld, tbl[i].d, tbl[i].rdy, tbl[i].fl, 1'b0);
      chk($sformatf("vec%0d_tvalid", i), m_tvalid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("vec%0d_tdata", i), m_tdata, tbl[i].ed);
      chk($sformatf("vec%0d_tlast", i), m_tlast, tbl[i].el);
    end
    chk("frame_idle", dut.state, IDLE);
    // overflow: 17 writes with no ready
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(1'b1, 64'h100 + 64'(k), 1'b0, 1'b0, 1'b0);
      chk($sformatf("ovf_afull_w%0d", k), almost_full, k >= 12);
      chk($sformatf("ovf_flag_w%0d", k), overflow, k >= 17);
    end
    step(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr_and_drop", overflow, 1);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("ovf_drain%0d_tvalid", k), m_tvalid, 1);
      chk($sformatf("ovf_drain%0d_tdata", k), m_tdata, 64'h100 + 64'(k));
      chk($sformatf("ovf_drain%0d_tlast", k), m_tlast, k % 8 == 0);
      step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("ovf_drained_tvalid", m_tvalid, 0);
    chk("ovf_drained_afull", almost_full, 0);
    chk("ovf_drained_idle", dut.state, IDLE);
    chk("ovf_sticky", overflow, 1);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", overflow, 0);
    // full boundary: write while full and popping
    for (int k = 1; k <= 16; k++) step(1'b1, 64'h200 + 64'(k), 1'b0, 1'b0, 1'b0);
    chk("full_count_before", dut.count, 16);
    step(1'b1, 64'hF00D, 1'b1, 1'b0, 1'b0);
    chk("full_ovf", overflow, 0);
    chk("full_count", dut.count, 16);
    chk("full_afull", almost_full, 1);
    for (int k = 2; k <= 17; k++) begin
      chk($sformatf("full_drain%0d", k), m_tdata, (k == 17) ? 64'hF00D : 64'h200 + 64'(k));
      step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("full_drained_tvalid", m_tvalid, 0);
    // flush: 3 beats, flush, 2 more
    do_reset();
    for (int k = 1; k <= 3; k++) step(1'b1, 64'h300 + 64'(k), 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("flush_drain_state", dut.state, DRAIN);
    for (int k = 1; k <= 2; k++) step(1'b1, 64'h310 + 64'(k), 1'b0, 1'b0, 1'b0);
    fl_data = '{64'h301, 64'h302, 64'h303, 64'h311, 64'h312};
    fl_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("flush_beat%0d_tdata", k), m_tdata, fl_data[k]);
      chk($sformatf("flush_beat%0d_tlast", k), m_tlast, fl_last[k]);
      if (k == 3) chk("flush_new_frame_fcnt", dut.fcnt, 0);
      step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("flush_after_state", dut.state, ACTIVE);
    chk("flush_after_fcnt", dut.fcnt, 2);
    step(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    chk("flush_empty_state", dut.state, DRAIN);
    step(1'b1, 64'h3FF0000000000000, 1'b1, 1'b0, 1'b0);
    chk("flush_empty_tvalid", m_tvalid, 1);
    chk("flush_empty_tlast", m_tlast, 1);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_empty_idle", dut.state, IDLE);
    chk("flush_empty_fcnt", dut.fcnt, 0);
    // reset mid-frame with 5 entries buffered
    for (int k = 1; k <= 5; k++) step(1'b1, 64'h400 + 64'(k), 1'b0, 1'b0, 1'b0);
    chk("rst2_pre_tvalid", m_tvalid, 1);
    @(negedge clk);
    psi_t_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_tvalid", m_tvalid, 0);
    chk("rst2_tdata", m_tdata, 0);
    chk("rst2_state", dut.state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("rst2_quiet%0d", k), m_tvalid, 0);
    end
    step(1'b1, 64'h500, 1'b0, 1'b0, 1'b0);
    chk("rst2_new_tvalid", m_tvalid, 1);
    chk("rst2_new_tdata", m_tdata, 64'h500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/psi_t_rx.md
PSI_T_RX -- requirements
Module: psi_t_rx

Interface
REQ-001 Parameter DEPTH, default 16, sets the FIFO depth in 64-bit entries; must be a power of two and at least 4.
REQ-002 Parameter FRAME_LEN, default 8, sets the number of output beats per frame; must be at least 1.
REQ-003 Parameter AFULL_MARGIN, default 4, sets the number of free entries at or below which almost_full asserts.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 psi_t  input  64  IEEE-754 double result word from the psi_t producer.
REQ-007 psi_t_vld  input  1  qualifies psi_t; the producer has no backpressure.
REQ-008 flush  input  1  one-cycle pulse that closes the current frame early.
REQ-009 clr_ovf  input  1  one-cycle pulse that clears the sticky overflow flag.
REQ-010 m_tdata  output  64  downstream data.
REQ-011 m_tvalid  output  1  downstream valid.
REQ-012 m_tready  input  1  downstream ready.
REQ-013 m_tlast  output  1  marks the last beat of a frame.
REQ-014 almost_full  output  1  tells the issuer to stop launching alpha_mul_k/psi_i pairs.
REQ-015 overflow  output  1  sticky flag: an input beat was dropped.

Function
REQ-016 A beat with psi_t_vld=1 is written to the FIFO in the same cycle whenever the FIFO is not full, or is full while a pop occurs in that same cycle.
REQ-017 A write to an empty FIFO appears on m_tdata with m_tvalid=1 on the next cycle (1-cycle latency, registered output).
REQ-018 A pop occurs exactly when m_tvalid && m_tready.
- m_tdata and m_tlast stay stable while m_tvalid && !m_tready.
REQ-019 A beat arriving while the FIFO is full and no pop occurs in that cycle is dropped.
- overflow is set on the following edge.
- The FIFO contents are unchanged.
REQ-020 overflow stays 1 until clr_ovf=1 or reset.
- If clr_ovf and a new drop occur in the same cycle, overflow stays 1.
REQ-021 almost_full = (DEPTH - count) <= AFULL_MARGIN, and is registered.
REQ-022 Frame counter fcnt, range 0..FRAME_LEN-1:
- m_tlast = 1 on the popped beat when fcnt == FRAME_LEN-1.
- fcnt increments on each pop and wraps to 0 after a tlast pop.
REQ-023 FSM state IDLE: fcnt == 0 and the FIFO is empty.
- Goes to ACTIVE on the first write.
REQ-024 FSM state ACTIVE: normal streaming.
- Goes to IDLE after a tlast pop that leaves the FIFO empty with no write in that cycle.
- Goes to DRAIN on flush=1.
REQ-025 FSM state DRAIN: input writes are still accepted, but only entries present when flush was sampled belong to the closing frame.
- m_tlast = 1 on the last of those entries, whether or not the frame is complete.
- After that pop: fcnt = 0, then go to ACTIVE if the FIFO is non-empty, otherwise IDLE.
REQ-026 flush in IDLE is ignored.
- flush in DRAIN is ignored.
- flush in ACTIVE with an empty FIFO and fcnt == 0 is ignored.
- flush in ACTIVE with an empty FIFO and fcnt > 0: the next pop carries m_tlast=1.
REQ-027 The FIFO read and write pointers are log2(DEPTH)+1 bits wide.
- full and empty come from pointer comparison.
- The pointers wrap without error.

Reset
REQ-028 While rst_n = 0, independent of clk:
- m_tvalid, m_tlast, almost_full and overflow are 0.
- m_tdata is 64'h0.
- The pointers and fcnt are 0.
- The FSM state is IDLE.
REQ-029 A reset asserted mid-frame discards all buffered entries; no beat is emitted after release until a new write.

Configuration
REQ-030 With macro PSI_T_RX_STATS_EN defined, two additional 32-bit outputs are present:
- beat_cnt counts accepted writes.
- drop_cnt counts dropped beats.
- Both saturate at 32'hFFFFFFFF and reset to 0.
REQ-031 Without PSI_T_RX_STATS_EN, those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-032 A shared package holds:
- the FSM state encoding (IDLE, ACTIVE, DRAIN);
- the 64-bit data width constant;
- the constant FP_NEG_SIXTH = 64'hBFC5555555555555, for bench reference-model use.
REQ-033 One sub-module, psi_t_rx_fifo (synchronous FIFO with count, full and empty), is instantiated once; the FSM and framing logic live in psi_t_rx.

Verification
REQ-034 Single write test: with reset released, write psi_t=64'h3FF0000000000000 for one cycle with m_tready=1 -> next cycle m_tvalid=1, m_tdata=64'h3FF0000000000000, m_tlast=0.
REQ-035 Frame test: stream 8 consecutive beats with m_tready=1 and FRAME_LEN=8 -> 8 output beats in order, m_tlast=1 only on the 8th, FSM returns to IDLE.
REQ-036 Overflow test: with m_tready=0, write 17 beats at DEPTH=16:
- almost_full rises after the 12th write;
- overflow=1 after the 17th;
- releasing ready yields exactly the first 16 beats;
- a clr_ovf pulse clears overflow.
REQ-037 Full boundary test: with the FIFO full and m_tready=1, one write -> no drop, overflow stays 0, count stays 16.
REQ-038 Flush test: write 3 beats, pulse flush, write 2 more -> the 3rd output beat has m_tlast=1, and the following frame starts at fcnt=0 with the 2 new beats.
REQ-039 Reset test: assert rst_n=0 with 5 entries buffered -> m_tvalid=0 immediately; after release, no output until a new write.
